il_modmul_digit_core: RTL

Interleaved modular multiplier core: computes r = a·b mod m by scanning a PBITS bits per step, MSB first. It starts the multiples-table calculator and then reads its precomputed tables: bxn[d] = d·b mod m, and mxn[j] = j·m. It sits downstream of the table calculator and starts it with a one-cycle enable pulse. When the calculator's done pulse arrives, the core accumulates, reduces and returns the residue.

---
 rtl/il_modmul_digit_core_if.sv | 27 ++
 rtl/il_modmul_digit_core.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/il_modmul_digit_core_if.sv
// rtl/il_modmul_digit_core_if.sv - operand, table and handshake bundle for il_modmul_digit_core
interface il_modmul_digit_core_if #(
  parameter int NBITS  = 4096,
  parameter int PBITS  = 1,
  parameter int MLSIZE = 1 << PBITS
);
  logic                              start;
  logic [NBITS-1:0]                  a;
  logic [NBITS-1:0]                  m;
  logic [MLSIZE*NBITS-1:0]           bxn_flat;
  logic [MLSIZE*(NBITS+PBITS)-1:0]   mxn_flat;
  logic                              tbl_done;
  logic                              calc_start;
  logic                              busy;
  logic                              done;
  logic [NBITS-1:0]                  result;

  modport master (
    output start, a, m, bxn_flat, mxn_flat, tbl_done,
    input  calc_start, busy, done, result
  );

  modport slave (
    input  start, a, m, bxn_flat, mxn_flat, tbl_done,
    output calc_start, busy, done, result
  );
endinterface

// File: rtl/il_modmul_digit_core.sv
// rtl/il_modmul_digit_core.sv - interleaved a*b mod m core consuming PBITS of a per step, MSB first
// Define ILMUL_PIPE_EN to register t between the add and the reduce stage (two cycles per digit).
module il_modmul_digit_core #(
  parameter int NBITS  = 4096,
  parameter int PBITS  = 1,
  parameter int MLSIZE = 1 << PBITS
) (
  input  logic                 clk,
  input  logic                 rst,
  il_modmul_digit_core_if.slave bus
);
  localparam int DIGITS = NBITS / PBITS;
  localparam int CW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int MW     = NBITS + PBITS;
  localparam int TW     = NBITS + PBITS + 1;

  typedef enum logic [1:0] {IDLE, WAIT_TBL, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [NBITS-1:0] acc_q, acc_d;
  logic [NBITS-1:0] sr_q, sr_d;
  logic [NBITS-1:0] result_q, result_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             calc_start_q, calc_start_d;
`ifdef ILMUL_PIPE_EN
  logic [TW-1:0]    t_q, t_d;
  logic             phase_q, phase_d;
`endif

  logic [PBITS-1:0] digit;
  logic [NBITS-1:0] bxn_sel;
  logic [TW-1:0]    t_c;
  logic [TW-1:0]    t_r;
  logic [TW-1:0]    sub;
  logic [NBITS-1:0] acc_red;
  logic             step_done;

  always_comb begin : datapath
    digit   = sr_q[NBITS-1 -: PBITS];
    bxn_sel = bus.bxn_flat[int'(digit)*NBITS +: NBITS];
    t_c     = (TW'(acc_q) << PBITS) + TW'(bxn_sel);
`ifdef ILMUL_PIPE_EN
    t_r = t_q;
`else
    t_r = t_c;
`endif
    // mxn grows with j, so the last entry not above t is the largest multiple to subtract.
    sub = '0;
    for (int j = 1; j <= MLSIZE; j++) begin
      if (TW'(bus.mxn_flat[(j-1)*MW +: MW]) <= t_r) begin
        sub = TW'(bus.mxn_flat[(j-1)*MW +: MW]);
      end
    end
    acc_red = NBITS'(t_r - sub);
  end

  always_comb begin : fsm
    state_d      = state_q;
    acc_d        = acc_q;
    sr_d         = sr_q;
    cnt_d        = cnt_q;
    result_d     = result_q;
    calc_start_d = 1'b0;
    step_done    = 1'b0;
`ifdef ILMUL_PIPE_EN
    t_d     = t_q;
    phase_d = phase_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          sr_d         = bus.a;
          acc_d        = '0;
          calc_start_d = 1'b1;
          state_d      = WAIT_TBL;
        end
      end
      WAIT_TBL: begin
        if (bus.tbl_done) begin
          cnt_d   = CW'(DIGITS - 1);
          state_d = RUN;
`ifdef ILMUL_PIPE_EN
          phase_d = 1'b0;
`endif
        end
      end
      RUN: begin
`ifdef ILMUL_PIPE_EN
        phase_d = ~phase_q;
        if (!phase_q) begin
          t_d  = t_c;
          sr_d = sr_q << PBITS;
        end else begin
          acc_d     = acc_red;
          step_done = 1'b1;
        end
`else
        sr_d      = sr_q << PBITS;
        acc_d     = acc_red;
        step_done = 1'b1;
`endif
        if (step_done) begin
          if (cnt_q == '0) begin
            state_d  = DONE;
            result_d = acc_red;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      sr_q         <= '0;
      cnt_q        <= '0;
      result_q     <= '0;
      calc_start_q <= 1'b0;
`ifdef ILMUL_PIPE_EN
      t_q          <= '0;
      phase_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      sr_q         <= sr_d;
      cnt_q        <= cnt_d;
      result_q     <= result_d;
      calc_start_q <= calc_start_d;
`ifdef ILMUL_PIPE_EN
      t_q          <= t_d;
      phase_q      <= phase_d;
`endif
    end
  end

  assign bus.calc_start = calc_start_q;
  assign bus.busy       = (state_q == WAIT_TBL) || (state_q == RUN);
  assign bus.done       = (state_q == DONE);
  assign bus.result     = result_q;
endmodule
